ram_bist_ctrl: RTL and testbench



---
 rtl/ram_bist_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: four-phase pattern BIST for a single-port RAM.
// Phases: W0 writes E(a,0), R0 reads and compares it, W1 writes E(a,1), and
// R1 reads and compares that. The first mismatch ends the test, and its
// address, data and phase are latched.
//
// start handshake: start is a single-cycle request with no ready. It is
// accepted only in IDLE or DONE, and is ignored while busy=1.
module ram_bist_ctrl #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] SEED     = 16'hA5C3,
    parameter int                READ_LAT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] Addr,
    output logic              Write_En,
    output logic [DATA_W-1:0] D,
    input  logic [DATA_W-1:0] O,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic              fail_phase,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_W0   = 3'd1,
        S_R0   = 3'd2,
        S_W1   = 3'd3,
        S_R1   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

    // Base pattern {a,~a} masked by SEED, and optionally inverted
    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                  input logic inv);
        return ({a, ~a} ^ SEED) ^ {DATA_W{inv}};
    endfunction

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_n, addr_inc;
    logic              we_n;
    logic [DATA_W-1:0] d_n;
    logic              busy_n, done_n, pass_n;
    logic [ADDR_W-1:0] fail_addr_n;
    logic [DATA_W-1:0] fail_data_n;
    logic              fail_phase_n;

    // Read pipeline: used only with a registered-read RAM
    logic              pipe_valid, pipe_valid_n;
    logic [ADDR_W-1:0] pipe_addr, pipe_addr_n;
    logic [DATA_W-1:0] pipe_exp, pipe_exp_n;
    logic              drain, drain_n;

    logic              inv, in_read;
    logic              cmp_valid, cmp_last, mismatch;
    logic [ADDR_W-1:0] cmp_addr;
    logic [DATA_W-1:0] cmp_exp;

    assign inv       = (state == S_W1) || (state == S_R1);
    assign in_read   = (state == S_R0) || (state == S_R1);
    assign addr_inc  = Addr + 1'b1;
    assign dbg_state = state;

    // Select which address/expectation is compared against O this cycle
    always_comb begin
        cmp_valid = 1'b0;
        cmp_addr  = Addr;
        cmp_exp   = pattern(Addr, inv);
        if (READ_LAT == 0) begin
            cmp_valid = in_read;
        end else begin
            cmp_valid = pipe_valid;
            cmp_addr  = pipe_addr;
            cmp_exp   = pipe_exp;
        end
    end

    assign mismatch = cmp_valid && (O != cmp_exp);
    assign cmp_last = cmp_valid && (cmp_addr == LAST_ADDR);

    // Next-state and next-output logic for the BIST sequencer
    always_comb begin
        state_n      = state;
        addr_n       = Addr;
        we_n         = 1'b0;
        d_n          = '0;
        busy_n       = busy;
        done_n       = done;
        pass_n       = pass;
        fail_addr_n  = fail_addr;
        fail_data_n  = fail_data;
        fail_phase_n = fail_phase;
        pipe_valid_n = 1'b0;
        pipe_addr_n  = pipe_addr;
        pipe_exp_n   = pipe_exp;
        drain_n      = drain;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n      = S_W0;
                    addr_n       = ZERO_ADDR;
                    we_n         = 1'b1;
                    d_n          = pattern(ZERO_ADDR, 1'b0);
                    busy_n       = 1'b1;
                    done_n       = 1'b0;
                    pass_n       = 1'b0;
                    fail_addr_n  = '0;
                    fail_data_n  = '0;
                    fail_phase_n = 1'b0;
                    drain_n      = 1'b0;
                end else if (state == S_DONE) begin
                    addr_n = ZERO_ADDR;
                end
            end

            S_W0, S_W1: begin
                // Terminal count is detected explicitly, so the counter never wraps
                if (Addr == LAST_ADDR) begin
                    state_n = (state == S_W0) ? S_R0 : S_R1;
                    addr_n  = ZERO_ADDR;
                    drain_n = 1'b0;
                end else begin
                    addr_n = addr_inc;
                    we_n   = 1'b1;
                    d_n    = pattern(addr_inc, inv);
                end
            end

            S_R0, S_R1: begin
                if (READ_LAT != 0) begin
                    // Issue stage: present addresses and stage their expectations
                    if (!drain) begin
                        pipe_valid_n = 1'b1;
                        pipe_addr_n  = Addr;
                        pipe_exp_n   = pattern(Addr, inv);
                        if (Addr == LAST_ADDR) begin
                            drain_n = 1'b1;
                        end else begin
                            addr_n = addr_inc;
                        end
                    end
                end else if (Addr != LAST_ADDR) begin
                    addr_n = addr_inc;
                end

                if (mismatch) begin
                    state_n      = S_DONE;
                    addr_n       = ZERO_ADDR;
                    busy_n       = 1'b0;
                    done_n       = 1'b1;
                    pass_n       = 1'b0;
                    fail_addr_n  = cmp_addr;
                    fail_data_n  = O;
                    fail_phase_n = (state == S_R1);
                    pipe_valid_n = 1'b0;
                    drain_n      = 1'b0;
                end else if (cmp_last) begin
                    addr_n       = ZERO_ADDR;
                    pipe_valid_n = 1'b0;
                    drain_n      = 1'b0;
                    if (state == S_R0) begin
                        state_n = S_W1;
                        we_n    = 1'b1;
                        d_n     = pattern(ZERO_ADDR, 1'b1);
                    end else begin
                        state_n = S_DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = 1'b1;
                    end
                end
            end

            default: begin
                state_n = S_IDLE;
                addr_n  = ZERO_ADDR;
            end
        endcase
    end

    // State and registered outputs; synchronous active-low reset clears all
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            Addr       <= '0;
            Write_En   <= 1'b0;
            D          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_addr  <= '0;
            fail_data  <= '0;
            fail_phase <= 1'b0;
            pipe_valid <= 1'b0;
            pipe_addr  <= '0;
            pipe_exp   <= '0;
            drain      <= 1'b0;
        end else begin
            state      <= state_n;
            Addr       <= addr_n;
            Write_En   <= we_n;
            D          <= d_n;
            busy       <= busy_n;
            done       <= done_n;
            pass       <= pass_n;
            fail_addr  <= fail_addr_n;
            fail_data  <= fail_data_n;
            fail_phase <= fail_phase_n;
            pipe_valid <= pipe_valid_n;
            pipe_addr  <= pipe_addr_n;
            pipe_exp   <= pipe_exp_n;
            drain      <= drain_n;
        end
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl. It runs two instances: a comb-read RAM with
// READ_LAT=0 and a registered-read RAM with READ_LAT=1. Each RAM model can
// force read-data bit 0 to a stuck value at one address.
`timescale 1ns/1ps
module tb_ram_bist_ctrl;

    localparam int DEPTH = 256;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start0 = 1'b0, start1 = 1'b0;
    logic [7:0]  addr0, addr1, fa0, fa1;
    logic        we0, we1, busy0, busy1, done0, done1, pass0, pass1, fp0, fp1;
    logic [15:0] d0, d1, o0, o1, fd0, fd1;
    logic [2:0]  st0, st1;

    logic        fault_en = 1'b0;
    logic [7:0]  fault_addr = 8'h00;
    logic        fault_val = 1'b0;

    logic [15:0] mem0 [DEPTH];
    logic [15:0] mem1 [DEPTH];

    function automatic logic [15:0] apply_fault(input logic [15:0] raw, input logic [7:0] a,
                                                input logic en, input logic [7:0] fa,
                                                input logic fv);
        logic [15:0] r;
        r = raw;
        if (en && a == fa) r[0] = fv;
        return r;
    endfunction

    ram_bist_ctrl #(.ADDR_W(8), .DATA_W(16), .SEED(16'hA5C3), .READ_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .Addr(addr0), .Write_En(we0), .D(d0),
        .O(o0), .busy(busy0), .done(done0), .pass(pass0), .fail_addr(fa0),
        .fail_data(fd0), .fail_phase(fp0), .dbg_state(st0)
    );

    ram_bist_ctrl #(.ADDR_W(8), .DATA_W(16), .SEED(16'hA5C3), .READ_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .Addr(addr1), .Write_En(we1), .D(d1),
        .O(o1), .busy(busy1), .done(done1), .pass(pass1), .fail_addr(fa1),
        .fail_data(fd1), .fail_phase(fp1), .dbg_state(st1)
    );

    // Comb-read RAM for instance 0
    always @(posedge clk) if (we0) mem0[addr0] <= d0;
    assign o0 = apply_fault(mem0[addr0], addr0, fault_en, fault_addr, fault_val);

    // Registered-read RAM for instance 1
    always @(posedge clk) begin
        if (we1) mem1[addr1] <= d1;
        o1 <= apply_fault(mem1[addr1], addr1, fault_en, fault_addr, fault_val);
    end

    // View of the instance under test
    logic        sel = 1'b0;
    logic        v_busy, v_done, v_pass, v_fp, v_we;
    logic [7:0]  v_addr, v_fa;
    logic [15:0] v_d, v_fd;
    assign v_busy = sel ? busy1 : busy0;
    assign v_done = sel ? done1 : done0;
    assign v_pass = sel ? pass1 : pass0;
    assign v_fp   = sel ? fp1   : fp0;
    assign v_we   = sel ? we1   : we0;
    assign v_addr = sel ? addr1 : addr0;
    assign v_fa   = sel ? fa1   : fa0;
    assign v_d    = sel ? d1    : d0;
    assign v_fd   = sel ? fd1   : fd0;

    // ---------------- write monitor ----------------
    logic        mon_clr = 1'b0;
    int          wr_count = 0;
    int          w12_n = 0;
    logic [15:0] w12 [2];

    always @(negedge clk) begin
        if (mon_clr) begin
            wr_count = 0;
            w12_n = 0;
        end else if (v_we) begin
            wr_count++;
            if (v_addr == 8'h12 && w12_n < 2) begin
                w12[w12_n] = v_d;
                w12_n++;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [25:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    typedef struct {
        logic        lat;
        logic        f_en;
        logic [7:0]  f_addr;
        logic        f_val;
        int          repulse;
        logic        done_before;
        logic        e_pass;
        logic [7:0]  e_fa;
        logic [15:0] e_fd;
        logic        e_fp;
        int          e_lat;
        int          e_wr;
    } vec_t;

    vec_t vecs[8];

    // ---------------- driver tasks ----------------
    task automatic set_start(input logic b);
        if (sel) start1 = b;
        else     start0 = b;
    endtask

    task automatic clear_monitor();
        @(posedge clk); #1 mon_clr = 1'b1;
        @(posedge clk); #1 mon_clr = 1'b0;
    endtask

    task automatic run_vec(input int i);
        vec_t        v;
        logic [25:0] exp_r;
        int          cyc;
        bit          got;
        v = vecs[i];
        sel = v.lat;
        fault_en = v.f_en;
        fault_addr = v.f_addr;
        fault_val = v.f_val;
        clear_monitor();
        check($sformatf("v%0d done_before", i), v_done, v.done_before);
        exp_q.push_back({v.e_pass, v.e_fa, v.e_fd, v.e_fp});
        @(negedge clk) set_start(1'b1);
        @(posedge clk); #1 set_start(1'b0);
        check($sformatf("v%0d start busy", i), v_busy, 1);
        check($sformatf("v%0d start done", i), v_done, 0);
        check($sformatf("v%0d start we", i), v_we, 1);
        check($sformatf("v%0d start addr", i), v_addr, 0);
        check($sformatf("v%0d start d", i), v_d, 16'hA53C);
        got = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 2000; c++) begin
            @(posedge clk); #1;
            set_start(c == v.repulse);
            cyc = c;
            if (v_done) begin
                got = 1'b1;
                break;
            end
        end
        set_start(1'b0);
        check($sformatf("v%0d done_seen", i), got, 1);
        exp_r = exp_q.pop_front();
        if (got) begin
            check($sformatf("v%0d pass", i), v_pass, exp_r[25]);
            check($sformatf("v%0d fail_addr", i), v_fa, exp_r[24:17]);
            check($sformatf("v%0d fail_data", i), v_fd, exp_r[16:1]);
            check($sformatf("v%0d fail_phase", i), v_fp, exp_r[0]);
            check($sformatf("v%0d latency", i), cyc, v.e_lat);
            check($sformatf("v%0d end busy", i), v_busy, 0);
            check($sformatf("v%0d end addr", i), v_addr, 0);
        end
        @(negedge clk);
        check($sformatf("v%0d writes", i), wr_count, v.e_wr);
        check($sformatf("v%0d w12 count", i), w12_n, v.e_wr / DEPTH);
        check($sformatf("v%0d w0 d@12", i), w12[0], 16'hB72E);
        if (v.e_wr == 2 * DEPTH) check($sformatf("v%0d w1 d@12", i), w12[1], 16'h48D1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        //             lat   fen   faddr  fval  rep done pass fa     fd         fp    lat   wr
        vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 0,   1'b0, 1'b1, 8'h00, 16'h0000, 1'b0, 1024, 512};
        vecs[1] = '{1'b0, 1'b1, 8'h34, 1'b1, 0,   1'b1, 1'b0, 8'h34, 16'h9109, 1'b0, 309,  256};
        vecs[2] = '{1'b0, 1'b1, 8'h9A, 1'b0, 0,   1'b1, 1'b0, 8'h9A, 16'hC058, 1'b1, 923,  512};
        vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 300, 1'b1, 1'b1, 8'h00, 16'h0000, 1'b0, 1024, 512};
        vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 0,   1'b0, 1'b1, 8'h00, 16'h0000, 1'b0, 1024, 512};
        vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 0,   1'b1, 1'b1, 8'h00, 16'h0000, 1'b0, 1024, 512};
        vecs[6] = '{1'b1, 1'b0, 8'h00, 1'b0, 0,   1'b0, 1'b1, 8'h00, 16'h0000, 1'b0, 1026, 512};
        vecs[7] = '{1'b1, 1'b1, 8'h34, 1'b1, 0,   1'b1, 1'b0, 8'h34, 16'h9109, 1'b0, 310,  256};

        // Reset state of both instances
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outs0", {busy0, done0, pass0, we0, fp0, addr0, d0, fa0, fd0}, 0);
        check("reset outs1", {busy1, done1, pass1, we1, fp1, addr1, d1, fa1, fd1}, 0);
        check("reset state0", st0, 0);
        check("reset state1", st1, 0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 4; i++) run_vec(i);

        // Reset pulse in the middle of W1
        sel = 1'b0;
        fault_en = 1'b0;
        @(negedge clk) start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        repeat (600) @(posedge clk);
        #1;
        check("midw1 state", st0, 3);
        check("midw1 we", we0, 1);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst outs", {busy0, done0, pass0, we0, fp0, addr0, d0, fa0, fd0}, 0);
        check("rst state", st0, 0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 4; i < 8; i++) run_vec(i);

        check("queue empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
